mem: RTL and testbench
======================

# mem

Single-port synchronous RAM used as a generic storage block (work RAM, stack page, scratch) on the CPU data bus. One clock, one address, one shared read/write port. Write data is captured on the rising clock edge when the write enable is high. Read data is registered with one cycle of latency.

## Interface
- `DEPTH`, default 256: number of `REG_WIDTH`-bit words. Any value ≥ 1 is legal; a power of two is not required.
- `clk`, in, 1: system clock. All activity happens on the rising edge (the bus phi0 clock).
- `reset_n`, in, 1: one clock; reset is synchronous and active-high. The port name is kept for bus compatibility; reset is asserted when the signal is 1.
- `we`, in, 1: write enable, 1 means write and 0 means read.
- `addr`, in, `ADDR_WIDTH` (16): word address.
- `din`, in, `REG_WIDTH` (8): write data.
- `dout`, out, `REG_WIDTH` (8): registered read data.

## Operation
- Storage is `DEPTH` words of `REG_WIDTH` bits each, implemented as flops or an inferred RAM.
- **Write:** on a rising edge with `we`=1 and `addr` < `DEPTH`, `mem[addr]` ← `din`.
- **Read:** on a rising edge with `we`=0 and `addr` < `DEPTH`, `dout` ← `mem[addr]`.
- **Write cycle output:** `dout` ← `din` (write-first). The written value is visible on `dout` after the same edge.
- **Out of range** (`addr` ≥ `DEPTH`):
  - Writes are ignored and memory is unchanged.
  - Reads drive `dout` ← 0.
  - In a write cycle, `dout` ← 0.
  - Out-of-range addresses never wrap or alias.
- **Reset:** on a rising edge with `reset_n`=1, all words are cleared to 0 and `dout` ← 0.
  - Reset has priority over `we`; a write in a reset cycle is discarded.
- Address comparison is unsigned over the full `ADDR_WIDTH`.
- Only the low `clog2(DEPTH)` bits index the array, and only after the range check passes.
- `din` and `addr` are don't-care while reset is asserted.

## Timing
- Read latency is 1 cycle: address presented before edge N gives data on `dout` after edge N, stable until edge N+1.
- Write latency is 0 cycles to storage. A read of the same address at edge N+1 returns the new value.
- A write at edge N followed by a read of the same address at edge N+1 returns the written data. This is the core write-then-read sequence.
- Back-to-back writes to the same address: the last write wins.
- `dout` changes only on rising edges and has no combinational path from inputs.
- Reset value of `dout` is 0, valid from the first edge with reset asserted.
- Reset mid-operation: the cycle with reset asserted performs no write, and memory reads as 0 from the next edge on.
- Inputs are sampled only at the rising edge. No handshake; the block is always ready.

## Structure
- The shared package supplies `REG_WIDTH` (8) and `ADDR_WIDTH` (16). This block adds no new package constants.
- Index width is a local constant equal to `clog2(DEPTH)`, minimum 1.
- A flat block with no sub-module is natural.

## Test plan
1. **Reset:** write 0xA5 to address 3, assert `reset_n`=1 for one edge, deassert, then read address 3.
   - `dout` = 0x00 after the reset edge and after the read edge.
2. **Random write-then-read:** 30 iterations with seed 33551 and `DEPTH`=32, each iteration:
   - one edge with `we`=1 and random `din`, `addr` % 32;
   - then one edge with `we`=0 at the same address.
   - `dout` equals the written `din` every iteration.
3. **Retention:**
   - Write 0x11 to address 0, 0x22 to address 31, and 0x33 to address 5.
   - Then read addresses 31, 0, 5.
   - `dout` = 0x22, 0x11, 0x33 on consecutive edges, one cycle after each address.
4. **Overwrite and write-first:**
   - Write 0x5A to address 7, then write 0xC3 to address 7.
   - `dout` shows 0x5A, then 0xC3, after each write edge.
   - A subsequent read of address 7 gives 0xC3.
5. **Out of range** (`DEPTH`=32):
   - Write 0xFF to address 32 and to address 0x8000.
   - Reads of those addresses give 0x00.
   - Address 0 (pre-written 0x44) still reads 0x44.
6. **Read during reset:** with address 3 holding 0x77, present a read of address 3 in the same cycle `reset_n`=1.
   - `dout` = 0x00.
   - A later read of address 3 is still 0x00.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared bus constants for the CPU data-bus storage blocks.
package mem_pkg;
    localparam int REG_WIDTH  = 8;
    localparam int ADDR_WIDTH = 16;
endpackage

// File: rtl/mem.sv
// Single-port synchronous RAM: write-first, registered read, synchronous clear.
// Out-of-range accesses never touch storage and return zero on dout.
module mem
    import mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [REG_WIDTH-1:0]  din,
    output logic [REG_WIDTH-1:0]  dout
);
    localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so a DEPTH of 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [REG_WIDTH-1:0] words [DEPTH];
    logic                 in_range;
    logic [IDX_WIDTH-1:0] idx;

    always_comb begin
        in_range = ({1'b0, addr} < DEPTH_LIMIT);
        idx      = addr[IDX_WIDTH-1:0];
    end

    // reset_n is active-high despite its name; it outranks any write.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                words[i] <= '0;
            end
            dout <= '0;
        end else if (in_range) begin
            if (we) begin
                words[idx] <= din;
                dout       <= din;
            end else begin
                dout <= words[idx];
            end
        end else begin
            dout <= '0;
        end
    end
endmodule

// File: tb/tb_mem.sv
// Directed bench for mem with DEPTH=32: reset, write-then-read, retention,
// write-first, out-of-range and reset-during-read behaviour.
module tb_mem;
    import mem_pkg::*;

    localparam int DEPTH = 32;

    logic                  clk;
    logic                  reset_n;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]  din;
    logic [REG_WIDTH-1:0]  dout;

    int total;
    int bad;

    mem #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .addr    (addr),
        .din     (din),
        .dout    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic w, input logic [ADDR_WIDTH-1:0] a,
                        input logic [REG_WIDTH-1:0] d);
        @(negedge clk);
        reset_n = rst;
        we      = w;
        addr    = a;
        din     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [REG_WIDTH-1:0] expected);
        total++;
        assert (dout === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, dout, expected);
        end
    endtask

    initial begin
        logic [ADDR_WIDTH-1:0] ra;
        logic [REG_WIDTH-1:0]  rd;
        int                    seed;

        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        we      = 1'b0;
        addr    = '0;
        din     = '0;

        // Reset clears storage and dout.
        step(1'b0, 1'b1, 16'd3, 8'hA5);
        check("wr3_a5", 8'hA5);
        step(1'b1, 1'b0, 16'd3, 8'h00);
        check("reset_dout", 8'h00);
        step(1'b0, 1'b0, 16'd3, 8'h00);
        check("read3_after_reset", 8'h00);

        // Random write-then-read.
        seed = 33551;
        void'($urandom(seed));
        for (int i = 0; i < 30; i++) begin
            ra = ADDR_WIDTH'($urandom_range(0, 65535) % DEPTH);
            rd = REG_WIDTH'($urandom_range(0, 255));
            step(1'b0, 1'b1, ra, rd);
            check("rand_wr_first", rd);
            step(1'b0, 1'b0, ra, 8'h00);
            check("rand_rd", rd);
        end

        // Retention across several addresses.
        step(1'b0, 1'b1, 16'd0, 8'h11);
        step(1'b0, 1'b1, 16'd31, 8'h22);
        step(1'b0, 1'b1, 16'd5, 8'h33);
        step(1'b0, 1'b0, 16'd31, 8'h00);
        check("ret_31", 8'h22);
        step(1'b0, 1'b0, 16'd0, 8'h00);
        check("ret_0", 8'h11);
        step(1'b0, 1'b0, 16'd5, 8'h00);
        check("ret_5", 8'h33);

        // Overwrite: last write wins, write-first on dout.
        step(1'b0, 1'b1, 16'd7, 8'h5A);
        check("ow_first", 8'h5A);
        step(1'b0, 1'b1, 16'd7, 8'hC3);
        check("ow_second", 8'hC3);
        step(1'b0, 1'b0, 16'd7, 8'h00);
        check("ow_read", 8'hC3);

        // Out of range: no write, no aliasing onto address 0, zero output.
        step(1'b0, 1'b1, 16'd0, 8'h44);
        check("oor_pre0", 8'h44);
        step(1'b0, 1'b1, 16'd32, 8'hFF);
        check("oor_wr32", 8'h00);
        step(1'b0, 1'b1, 16'h8000, 8'hFF);
        check("oor_wr8000", 8'h00);
        step(1'b0, 1'b0, 16'd32, 8'h00);
        check("oor_rd32", 8'h00);
        step(1'b0, 1'b0, 16'h8000, 8'h00);
        check("oor_rd8000", 8'h00);
        step(1'b0, 1'b0, 16'd0, 8'h00);
        check("oor_addr0_kept", 8'h44);
        step(1'b0, 1'b0, 16'hFFFF, 8'h00);
        check("oor_rdffff", 8'h00);

        // Read presented in a reset cycle, and a write discarded by reset.
        step(1'b0, 1'b1, 16'd3, 8'h77);
        check("rr_wr3", 8'h77);
        step(1'b1, 1'b0, 16'd3, 8'h00);
        check("rr_reset_read", 8'h00);
        step(1'b0, 1'b0, 16'd3, 8'h00);
        check("rr_read3_later", 8'h00);
        step(1'b1, 1'b1, 16'd9, 8'h99);
        check("rst_write_dout", 8'h00);
        step(1'b0, 1'b0, 16'd9, 8'h00);
        check("rst_write_discarded", 8'h00);
        step(1'b0, 1'b0, 16'd31, 8'h00);
        check("reset_cleared_31", 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
